// File: rtl/bz_mem_pkg.sv
// Shared memory-map constants and types for the vector-RAM path.
// Used by vram_port_arbiter and vram_write_hold.
package bz_mem_pkg;

    localparam logic [15:0] VRAM_BASE   = 16'h2000;
    localparam int          VRAM_ADDR_W = 12;

    typedef logic [VRAM_ADDR_W-1:0] vram_addr_t;

    typedef struct packed {
        vram_addr_t  addr;
        logic [7:0]  data;
    } mem_wr_t;

    // Offset is already base-relative; in window if no bits at or above aw.
    function automatic logic in_window(input logic [15:0] off, input int aw);
        return (off >> aw) == 16'h0;
    endfunction

endpackage

// File: rtl/vram_write_hold.sv
// One-entry write holding register between the CPU store queue and VRAM.
// Does the window check, wr_drop pulse and read-forwarding compare.
module vram_write_hold #(
    parameter logic [15:0] BASE   = 16'h2000,
    parameter int          ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        sq_data,
    input  logic [15:0]       sq_addr,
    input  logic              sq_write,
    input  logic              drain,
    input  logic [ADDR_W-1:0] vg_addr,
    output logic              can_write,
    output logic              hold_valid,
    output logic [ADDR_W-1:0] hold_addr,
    output logic [7:0]        hold_data,
    output logic              wr_drop,
    output logic              fwd_hit
);
    import bz_mem_pkg::*;

    logic [15:0] offset;
    logic        in_win;
    logic        accept;
    logic        drop_q;

    assign offset    = sq_addr - BASE;
    assign in_win    = in_window(offset, ADDR_W);
    assign can_write = !rst && !hold_valid;
    assign accept    = sq_write && can_write;
    assign wr_drop   = drop_q && !rst;
    assign fwd_hit   = hold_valid && (vg_addr == hold_addr);

    // Load on an in-window accept, release when the port drains it.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid <= 1'b0;
            hold_addr  <= '0;
            hold_data  <= 8'h00;
            drop_q     <= 1'b0;
        end else begin
            drop_q <= accept && !in_win;
            if (accept && in_win) begin
                hold_valid <= 1'b1;
                hold_addr  <= offset[ADDR_W-1:0];
                hold_data  <= sq_data;
            end else if (drain) begin
                hold_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/vram_port_arbiter.sv
// Shares the vector-RAM BRAM port between store-queue drains and VG reads.
// Define VRAM_ARB_FAIRNESS_EN to bound how long a pending write can starve.
module vram_port_arbiter #(
    parameter logic [15:0] VRAM_BASE     = bz_mem_pkg::VRAM_BASE,
    parameter int          ADDR_W        = bz_mem_pkg::VRAM_ADDR_W,
    parameter int          MAX_VG_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        sq_data,
    input  logic [15:0]       sq_addr,
    input  logic              sq_write,
    output logic              sq_can_write,
    input  logic              vg_req,
    input  logic [ADDR_W-1:0] vg_addr,
    output logic              vg_gnt,
    output logic              vg_rvalid,
    output logic [7:0]        vg_rdata,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [7:0]        bram_wdata,
    output logic              bram_we,
    input  logic [7:0]        bram_rdata,
    output logic              wr_drop
);
    logic              hold_valid;
    logic [ADDR_W-1:0] hold_addr;
    logic [7:0]        hold_data;
    logic              fwd_hit;
    logic              force_wr;
    logic              drain;
    logic              rvalid_q;
    logic              fwd_sel;
    logic [7:0]        fwd_data;

    vram_write_hold #(
        .BASE   (VRAM_BASE),
        .ADDR_W (ADDR_W)
    ) u_hold (
        .clk        (clk),
        .rst        (rst),
        .sq_data    (sq_data),
        .sq_addr    (sq_addr),
        .sq_write   (sq_write),
        .drain      (drain),
        .vg_addr    (vg_addr),
        .can_write  (sq_can_write),
        .hold_valid (hold_valid),
        .hold_addr  (hold_addr),
        .hold_data  (hold_data),
        .wr_drop    (wr_drop),
        .fwd_hit    (fwd_hit)
    );

`ifdef VRAM_ARB_FAIRNESS_EN
    localparam int SW = $clog2(MAX_VG_STREAK + 1);
    logic [SW-1:0] streak;

    assign force_wr = (streak == SW'(MAX_VG_STREAK));

    // Count VG grants that bypassed a pending write.
    always_ff @(posedge clk) begin
        if (rst || !hold_valid || drain)
            streak <= '0;
        else if (vg_gnt)
            streak <= streak + SW'(1);
    end
`else
    assign force_wr = 1'b0;
`endif

    assign vg_gnt = !rst && vg_req && !force_wr;
    assign drain  = !rst && !vg_gnt && hold_valid;

    // Port mux: VG read first, else drain the held write, else idle.
    always_comb begin
        bram_addr  = '0;
        bram_wdata = 8'h00;
        bram_we    = 1'b0;
        if (vg_gnt) begin
            bram_addr = vg_addr;
        end else if (drain) begin
            bram_addr  = hold_addr;
            bram_wdata = hold_data;
            bram_we    = 1'b1;
        end
    end

    // Read-valid pipeline; a hit on the held write returns the held byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            rvalid_q <= 1'b0;
            fwd_sel  <= 1'b0;
            fwd_data <= 8'h00;
        end else begin
            rvalid_q <= vg_gnt;
            fwd_sel  <= vg_gnt && fwd_hit;
            if (vg_gnt && fwd_hit)
                fwd_data <= hold_data;
        end
    end

    assign vg_rvalid = rvalid_q && !rst;
    assign vg_rdata  = !vg_rvalid ? 8'h00 :
                       fwd_sel    ? fwd_data : bram_rdata;

endmodule

// File: tb/tb_vram_port_arbiter.sv
// Self-checking bench for vram_port_arbiter: directed scenarios then random
// traffic against a logical-memory reference model.
module tb_vram_port_arbiter;

    localparam int MAX = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  sq_data = 8'h00;
    logic [15:0] sq_addr = 16'h0000;
    logic        sq_write = 1'b0;
    logic        sq_can_write;
    logic        vg_req = 1'b0;
    logic [11:0] vg_addr = 12'h000;
    logic        vg_gnt;
    logic        vg_rvalid;
    logic [7:0]  vg_rdata;
    logic [11:0] bram_addr;
    logic [7:0]  bram_wdata;
    logic        bram_we;
    logic [7:0]  bram_rdata = 8'h00;
    logic        wr_drop;

    always #5 clk = ~clk;

    vram_port_arbiter #(
        .VRAM_BASE     (16'h2000),
        .ADDR_W        (12),
        .MAX_VG_STREAK (MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sq_data      (sq_data),
        .sq_addr      (sq_addr),
        .sq_write     (sq_write),
        .sq_can_write (sq_can_write),
        .vg_req       (vg_req),
        .vg_addr      (vg_addr),
        .vg_gnt       (vg_gnt),
        .vg_rvalid    (vg_rvalid),
        .vg_rdata     (vg_rdata),
        .bram_addr    (bram_addr),
        .bram_wdata   (bram_wdata),
        .bram_we      (bram_we),
        .bram_rdata   (bram_rdata),
        .wr_drop      (wr_drop)
    );

    // Physical BRAM: synchronous write, 1-cycle read latency.
    logic [7:0] phys [4096];
    always @(posedge clk) begin
        if (bram_we) phys[bram_addr] <= bram_wdata;
        bram_rdata <= phys[bram_addr];
    end

    // Reference model: what a reader should see in vector RAM.
    logic [7:0]  mem [4096];
    logic        p_valid = 1'b0;
    logic [11:0] p_addr = 12'h0;
    logic [7:0]  p_data = 8'h0;
    logic [7:0]  p_old = 8'h0;
    int          skipped = 0;
    logic        rd_valid = 1'b0;
    logic [7:0]  rd_data = 8'h0;
    logic        drop_next = 1'b0;

    logic        obs_can, obs_gnt, obs_we, obs_rv, obs_drop;
    logic [11:0] obs_addr;
    logic [7:0]  obs_wd, obs_rd;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        logic        fforce, egnt, ewe, ecan;
        logic [11:0] eaddr;
        logic [15:0] off;
        fforce = 1'b0;
`ifdef VRAM_ARB_FAIRNESS_EN
        fforce = p_valid && (skipped >= MAX);
`endif
        ecan  = !p_valid;
        egnt  = vg_req && !fforce;
        ewe   = p_valid && !egnt;
        eaddr = egnt ? vg_addr : (ewe ? p_addr : 12'h000);
        @(negedge clk);
        obs_can  = sq_can_write;
        obs_gnt  = vg_gnt;
        obs_we   = bram_we;
        obs_rv   = vg_rvalid;
        obs_drop = wr_drop;
        obs_addr = bram_addr;
        obs_wd   = bram_wdata;
        obs_rd   = vg_rdata;
        chk("can_write", 16'(obs_can), 16'(ecan));
        chk("vg_gnt", 16'(obs_gnt), 16'(egnt));
        chk("bram_we", 16'(obs_we), 16'(ewe));
        chk("bram_addr", 16'(obs_addr), 16'(eaddr));
        if (ewe) chk("bram_wdata", 16'(obs_wd), 16'(p_data));
        chk("vg_rvalid", 16'(obs_rv), 16'(rd_valid));
        if (rd_valid) chk("vg_rdata", 16'(obs_rd), 16'(rd_data));
        chk("wr_drop", 16'(obs_drop), 16'(drop_next));
        rd_valid = egnt;
        rd_data  = mem[vg_addr];
        if (ewe) begin
            p_valid = 1'b0;
            skipped = 0;
        end else if (egnt && p_valid) begin
            skipped++;
        end
        drop_next = 1'b0;
        if (sq_write && ecan) begin
            off = sq_addr - 16'h2000;
            if (off < 16'h1000) begin
                p_valid = 1'b1;
                p_addr  = off[11:0];
                p_data  = sq_data;
                p_old   = mem[off[11:0]];
                mem[off[11:0]] = sq_data;
            end else begin
                drop_next = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_can_write", 16'(sq_can_write), 16'h0);
            chk("rst_vg_gnt", 16'(vg_gnt), 16'h0);
            chk("rst_bram_we", 16'(bram_we), 16'h0);
            chk("rst_bram_addr", 16'(bram_addr), 16'h0);
            chk("rst_bram_wdata", 16'(bram_wdata), 16'h0);
            chk("rst_vg_rvalid", 16'(vg_rvalid), 16'h0);
            chk("rst_vg_rdata", 16'(vg_rdata), 16'h0);
            chk("rst_wr_drop", 16'(wr_drop), 16'h0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        if (p_valid) mem[p_addr] = p_old;
        p_valid   = 1'b0;
        skipped   = 0;
        rd_valid  = 1'b0;
        drop_next = 1'b0;
    endtask

    initial begin
        int          g;
        logic        we_seen;
        int          nbad;
        logic [7:0]  rdexp [4];
        for (int i = 0; i < 4096; i++) begin
            phys[i] = 8'(i) ^ 8'h5C;
            mem[i]  = 8'(i) ^ 8'h5C;
        end
        rdexp[0] = 8'h11; rdexp[1] = 8'h22;
        rdexp[2] = 8'h33; rdexp[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            phys[12'h100 + i] = rdexp[i];
            mem[12'h100 + i]  = rdexp[i];
        end
        phys[12'h020] = 8'h77; mem[12'h020] = 8'h77;
        phys[12'h060] = 8'h66; mem[12'h060] = 8'h66;

        vg_req = 1'b1;
        do_reset();
        vg_req = 1'b0;

        // Idle write
        sq_addr = 16'h2010; sq_data = 8'hA5; sq_write = 1'b1;
        cycle();
        chk("idle_can_first", 16'(obs_can), 16'h1);
        sq_write = 1'b0;
        cycle();
        chk("idle_we", 16'(obs_we), 16'h1);
        chk("idle_addr", 16'(obs_addr), 16'h010);
        chk("idle_wdata", 16'(obs_wd), 16'h00A5);
        chk("idle_can_low", 16'(obs_can), 16'h0);
        cycle();
        chk("idle_can_back", 16'(obs_can), 16'h1);

        // Out-of-window write
        sq_addr = 16'h3000; sq_data = 8'h99; sq_write = 1'b1;
        cycle();
        sq_write = 1'b0;
        cycle();
        chk("oow_drop", 16'(obs_drop), 16'h1);
        chk("oow_we", 16'(obs_we), 16'h0);
        chk("oow_can", 16'(obs_can), 16'h1);
        cycle();
        chk("oow_drop_once", 16'(obs_drop), 16'h0);

        // Read latency, back-to-back
        vg_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            vg_addr = 12'h100 + 12'(i);
            if (i == 4) vg_req = 1'b0;
            cycle();
            if (i > 0) begin
                chk("rd_rvalid", 16'(obs_rv), 16'h1);
                chk("rd_data", 16'(obs_rd), 16'(rdexp[i-1]));
            end
        end

        // Forwarding from the held write
        sq_addr = 16'h2020; sq_data = 8'h5A; sq_write = 1'b1;
        vg_req = 1'b1; vg_addr = 12'h030;
        cycle();
        sq_write = 1'b0; vg_addr = 12'h020;
        cycle();
        vg_req = 1'b0;
        cycle();
        chk("fwd_rdata", 16'(obs_rd), 16'h005A);

        // Fairness under continuous VG traffic
        sq_addr = 16'h2040; sq_data = 8'hC3; sq_write = 1'b1;
        vg_req = 1'b1; vg_addr = 12'h050;
        cycle();
        sq_write = 1'b0;
        g = 0; we_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            if (obs_we) begin
                we_seen = 1'b1;
                break;
            end
            if (obs_gnt) g++;
        end
`ifdef VRAM_ARB_FAIRNESS_EN
        chk("fair_we", 16'(we_seen), 16'h1);
        chk("fair_grants", 16'(g), 16'(MAX));
        vg_req = 1'b0;
        cycle();
`else
        chk("prio_no_we", 16'(we_seen), 16'h0);
        vg_req = 1'b0;
        cycle();
        chk("prio_we_on_idle", 16'(obs_we), 16'h1);
`endif

        // Reset while a write is held
        sq_addr = 16'h2060; sq_data = 8'hEE; sq_write = 1'b1;
        vg_req = 1'b1; vg_addr = 12'h070;
        cycle();
        sq_write = 1'b0;
        cycle();
        do_reset();
        vg_req = 1'b0;
        cycle();
        chk("rsth_can", 16'(obs_can), 16'h1);
        chk("rsth_we", 16'(obs_we), 16'h0);
        cycle();
        chk("rsth_we2", 16'(obs_we), 16'h0);
        vg_req = 1'b1; vg_addr = 12'h060;
        cycle();
        vg_req = 1'b0;
        cycle();
        chk("rsth_mem", 16'(obs_rd), 16'h0066);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            int r;
            vg_req = ($urandom_range(0, 99) < 60);
            vg_addr = ($urandom_range(0, 3) == 0) ? 12'($urandom)
                                                   : {8'h00, 4'($urandom)};
            sq_write = ($urandom_range(0, 99) < 35);
            sq_data = 8'($urandom);
            r = $urandom_range(0, 9);
            case (r)
                0: sq_addr = 16'h3000;
                1: sq_addr = 16'h1FFF;
                2: sq_addr = 16'($urandom);
                default: sq_addr = 16'h2000 + 16'($urandom_range(0, 15));
            endcase
            cycle();
            if (i % 1000 == 999) do_reset();
        end

        vg_req = 1'b0; sq_write = 1'b0;
        cycle();
        cycle();
        nbad = 0;
        for (int i = 0; i < 4096; i++)
            if (phys[i] !== mem[i]) nbad++;
        chk("bram_image", 16'(nbad), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vram_port_arbiter.md
# vram_port_arbiter

Owns the single read/write port of the vector-RAM BRAM (CPU window 0x2000–0x2FFF) and shares it between the 6502 store-queue drain and the vector generator's list fetches. Sits directly downstream of the CPU store queue: it drives that queue's `canWrite` and consumes its `writeOut`/`writeAddr`/`Q`. A one-entry write holding register breaks the combinational `canWrite`→`writeOut` loop. Read data is forwarded from the holding register so the vector generator never sees a stale byte.

## Interface
Parameters:
- `VRAM_BASE`, 16'h2000, CPU address of vector-RAM byte 0.
- `ADDR_W`, 12, BRAM address width; the window is 2^ADDR_W bytes.
- `MAX_VG_STREAK`, 4, consecutive VG grants tolerated while a write is pending (fairness only).

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset, synchronous, active-high.
- `sq_data` in 8: store-queue head data (`Q`).
- `sq_addr` in 16: store-queue head CPU address.
- `sq_write` in 1: store-queue pop strobe (`writeOut`).
- `sq_can_write` out 1: accept strobe to store queue (`canWrite`).
- `vg_req` in 1: vector generator read request.
- `vg_addr` in ADDR_W: VG read address.
- `vg_gnt` out 1: VG read granted this cycle.
- `vg_rvalid` out 1: VG read data valid.
- `vg_rdata` out 8: VG read data.
- `bram_addr` out ADDR_W: BRAM port address.
- `bram_wdata` out 8: BRAM write data.
- `bram_we` out 1: BRAM write enable.
- `bram_rdata` in 8: BRAM read data, 1-cycle latency.
- `wr_drop` out 1: one-cycle pulse; an accepted write fell outside the window.

## Operation
- Holding register: `hold_valid`, `hold_addr[ADDR_W-1:0]`, `hold_data[7:0]`.
- `sq_can_write = !rst && !hold_valid`. This is a function of registered state only and never depends on `sq_write`.
- Accept happens when `sq_write && sq_can_write`:
  - If `sq_addr - VRAM_BASE < 2^ADDR_W` (unsigned, 16-bit), load the hold register and set `hold_valid`.
  - Otherwise, do not load, pulse `wr_drop` the next cycle, and keep `sq_can_write` high.
- Port decision each cycle, combinational from `vg_req`, `hold_valid` and `force_wr`:
  - `vg_req && !force_wr`: `vg_gnt=1`, `bram_addr=vg_addr`, `bram_we=0`.
  - Else if `hold_valid`: `bram_we=1`, `bram_addr=hold_addr`, `bram_wdata=hold_data`; clear `hold_valid` next cycle.
  - Else: port idle, `bram_addr=0`, `bram_we=0`.
- Streak counter, `$clog2(MAX_VG_STREAK+1)` bits:
  - Increments on each VG grant while `hold_valid`.
  - Clears when the hold drains or `hold_valid=0`.
  - `force_wr = (streak == MAX_VG_STREAK)`, only when fairness is compiled in.
- Forwarding: on a VG grant with `hold_valid && vg_addr == hold_addr`, latch `hold_data` and select it for `vg_rdata` next cycle instead of `bram_rdata`.
- A drain and a new accept never occur in the same cycle, because accept requires `!hold_valid`.

## Timing
- Reset values:
  - `sq_can_write=0` during reset, 1 on the first cycle after reset.
  - `vg_gnt`, `vg_rvalid`, `vg_rdata`, `bram_we`, `bram_addr`, `bram_wdata`, `wr_drop` all 0.
  - `hold_valid=0`, streak 0.
- `vg_gnt` is asserted in the same cycle as `vg_req`. `vg_rvalid`/`vg_rdata` follow exactly 1 cycle after `vg_gnt`.
- Write path: accept at cycle N, hold valid at N+1, earliest `bram_we` at N+1. Peak throughput is one write per 2 cycles.
- `wr_drop` fires at N+1 for a rejected write.
- Reset asserted mid-operation:
  - The held write is discarded (never reaches BRAM).
  - A pending `vg_rvalid` is squashed.
  - The streak is cleared.

## Configuration
- `VRAM_ARB_FAIRNESS_EN` defined: a pending write is guaranteed to drain within `MAX_VG_STREAK+1` cycles. On the forced cycle `vg_gnt=0` even though `vg_req=1`.
- Not defined: strict VG priority. `force_wr` is tied 0, the streak counter is removed, and a write drains only on cycles with `vg_req=0`.

## Structure
- Shared package `bz_mem_pkg` holds:
  - `VRAM_BASE`
  - `VRAM_ADDR_W`
  - typedef `vram_addr_t` (logic [VRAM_ADDR_W-1:0])
  - typedef `mem_wr_t` (struct: addr, data)
- Sub-module `vram_write_hold` contains the holding register, the window check, `wr_drop` generation and the forwarding compare. The top level keeps the port mux, the streak counter and the read-valid pipeline.

## Test plan
- **Idle write:** `sq_addr=16'h2010`, `sq_data=8'hA5`, one `sq_write`, no `vg_req` → `bram_we=1` with `bram_addr=12'h010`, `bram_wdata=8'hA5` one cycle later; `sq_can_write` low for exactly 1 cycle.
- **Out-of-window write:** write to 16'h3000 → no `bram_we`; `wr_drop` pulses once; `sq_can_write` stays 1.
- **Read latency:** `vg_req` continuous at 12'h100..12'h103 with BRAM preloaded → `vg_rvalid` 1 cycle after each `vg_gnt`, data in order.
- **Forwarding:** hold 12'h020=8'h5A pending, `vg_req` at 12'h020 → `vg_rdata=8'h5A` the next cycle, not the old BRAM value.
- **Fairness:** `vg_req` held high with a write pending, macro on → `vg_gnt` drops and `bram_we=1` after exactly 4 grants. Macro off → the write waits until `vg_req` falls.
- **Reset mid-hold:** `rst` pulsed while `hold_valid=1` → no `bram_we` afterward; BRAM location unchanged; `sq_can_write=1` the cycle after reset.
